// File: rtl/oam_dma_controller.sv
// OAM DMA sequencer: copies NUM_BYTES from {src_hi, 8'h00} into OAM,
// one byte per CYCLES_PER_BYTE clocks, after a one-window start delay.
module oam_dma_controller #(
   parameter int CYCLES_PER_BYTE = 4,
   parameter int NUM_BYTES       = 160,
   parameter int ECHO_FOLD       = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        reg_wr_en,
   input  logic [7:0]  reg_wdata,
   output logic [7:0]  reg_rdata,
   output logic        dma_active,
   output logic        rd_req,
   output logic [15:0] rd_addr,
   input  logic [7:0]  rd_data,
   output logic        oam_wr_en,
   output logic [7:0]  oam_addr,
   output logic [7:0]  oam_wdata
);

   localparam int TW = $clog2(CYCLES_PER_BYTE);
   localparam logic [TW-1:0] TICK_LAST = TW'(CYCLES_PER_BYTE - 1);
   localparam logic [7:0]    IDX_LAST  = 8'(NUM_BYTES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_XFER
   } state_t;

   state_t        r_state;
   logic [7:0]    r_src_hi;
   logic [7:0]    r_rdata;
   logic [7:0]    r_index;
   logic [TW-1:0] r_tick;

   logic          w_tick_last;
   logic          w_fold;
   logic [7:0]    w_src_eff;

   assign w_tick_last = (r_tick == TICK_LAST);
   // Echo RAM E000-FDFF mirrors C000-DDFF on the source bus
   assign w_fold      = (ECHO_FOLD != 0) && (r_src_hi >= 8'hE0);
   assign w_src_eff   = w_fold ? (r_src_hi - 8'h20) : r_src_hi;
   assign reg_rdata   = r_rdata;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_src_hi <= 8'h00;
         r_rdata  <= 8'hFF;
         r_index  <= 8'h00;
         r_tick   <= '0;
      end else if (reg_wr_en) begin
         // a write in any state (re)starts the copy from byte 0
         r_state  <= S_START;
         r_src_hi <= reg_wdata;
         r_rdata  <= reg_wdata;
         r_index  <= 8'h00;
         r_tick   <= '0;
      end else begin
         unique case (r_state)
            S_START: begin
               if (w_tick_last) begin
                  r_state <= S_XFER;
                  r_index <= 8'h00;
                  r_tick  <= '0;
               end else begin
                  r_tick <= r_tick + 1'b1;
               end
            end
            S_XFER: begin
               if (w_tick_last) begin
                  r_tick <= '0;
                  if (r_index == IDX_LAST) begin
                     r_state <= S_IDLE;
                     r_index <= 8'h00;
                  end else begin
                     r_index <= r_index + 8'd1;
                  end
               end else begin
                  r_tick <= r_tick + 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // strobes decode straight from state/index/tick, no output register
   always_comb begin
      dma_active = (r_state != S_IDLE);
      rd_req     = 1'b0;
      rd_addr    = 16'h0000;
      oam_wr_en  = 1'b0;
      oam_addr   = 8'h00;
      oam_wdata  = 8'h00;
      if (r_state == S_XFER) begin
         if (r_tick == TW'(0)) begin
            rd_req  = 1'b1;
            rd_addr = {w_src_eff, r_index};
         end
         if (r_tick == TW'(1)) begin
            oam_wr_en = 1'b1;
            oam_addr  = r_index;
            oam_wdata = rd_data;
         end
      end
   end

endmodule

// File: tb/tb_oam_dma_controller.sv
// Randomized bench for oam_dma_controller, checked cycle by cycle
// against a timeline model derived from the write/reset history.
module tb_oam_dma_controller;

   localparam int CPB  = 4;
   localparam int NB   = 160;
   localparam int MAXC = 20000;

   typedef struct packed {
      logic        act;
      logic        rq;
      logic [15:0] ra;
      logic        wr;
      logic [7:0]  oa;
      logic [7:0]  od;
      logic [7:0]  rb;
   } obs_t;

   typedef struct {
      int         c;
      bit         rst;
      logic [7:0] d;
   } ev_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        reg_wr_en = 1'b0;
   logic [7:0]  reg_wdata = 8'h00;
   logic [7:0]  reg_rdata;
   logic        dma_active;
   logic        rd_req;
   logic [15:0] rd_addr;
   logic [7:0]  rd_data = 8'h00;
   logic        oam_wr_en;
   logic [7:0]  oam_addr;
   logic [7:0]  oam_wdata;

   int   cyc = 0;
   int   ncmp = 0;
   int   nerr = 0;
   int   bw = 0;
   obs_t obs [0:MAXC-1];
   ev_t  evq [$];
   logic        lrq = 1'b0;
   logic [15:0] lra = 16'h0000;

   oam_dma_controller #(
      .CYCLES_PER_BYTE(CPB),
      .NUM_BYTES(NB),
      .ECHO_FOLD(1)
   ) dut (
      .clk(clk),
      .reset(reset),
      .reg_wr_en(reg_wr_en),
      .reg_wdata(reg_wdata),
      .reg_rdata(reg_rdata),
      .dma_active(dma_active),
      .rd_req(rd_req),
      .rd_addr(rd_addr),
      .rd_data(rd_data),
      .oam_wr_en(oam_wr_en),
      .oam_addr(oam_addr),
      .oam_wdata(oam_wdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   function automatic logic [7:0] mem(input logic [15:0] a);
      return a[7:0] ^ 8'h5A;
   endfunction

   always @(negedge clk) begin
      if (cyc < MAXC)
         obs[cyc] = {dma_active, rd_req, rd_addr, oam_wr_en,
                     oam_addr, oam_wdata, reg_rdata};
      lrq = rd_req;
      lra = rd_addr;
   end

   // memory answers one cycle after rd_req; noise otherwise
   always @(posedge clk) begin
      #1;
      rd_data = lrq ? mem(lra) : 8'($urandom);
   end

   // Expected outputs in cycle c from the last write/reset before it
   function automatic obs_t model(input int c);
      obs_t       e;
      int         k, d, i, t;
      logic [7:0] s, eff;
      e = '0;
      k = -1;
      foreach (evq[j]) if (evq[j].c < c) k = j;
      if (k < 0) return e;
      if (evq[k].rst) begin
         e.rb = 8'hFF;
         return e;
      end
      s    = evq[k].d;
      e.rb = s;
      d    = c - evq[k].c - 1;
      if (d >= CPB * (NB + 1)) return e;
      e.act = 1'b1;
      if (d < CPB) return e;
      i   = (d - CPB) / CPB;
      t   = (d - CPB) % CPB;
      eff = (s >= 8'hE0) ? s - 8'h20 : s;
      if (t == 0) begin
         e.rq = 1'b1;
         e.ra = {eff, 8'(i)};
      end
      if (t == 1) begin
         e.wr = 1'b1;
         e.oa = 8'(i);
         e.od = mem({eff, 8'(i)});
      end
      return e;
   endfunction

   function automatic bit bad(input obs_t o, input obs_t e);
      return o.act !== e.act || o.rq !== e.rq || o.wr !== e.wr ||
             o.rb !== e.rb || (e.rq && o.ra !== e.ra) ||
             (e.wr && (o.oa !== e.oa || o.od !== e.od));
   endfunction

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic strobe(input logic [7:0] d);
      reg_wr_en = 1'b1;
      reg_wdata = d;
      evq.push_back('{cyc, 1'b0, d});
      @(negedge clk);
      reg_wr_en = 1'b0;
   endtask

   task automatic pulse_reset(input int n);
      repeat (n) begin
         reset = 1'b1;
         evq.push_back('{cyc, 1'b1, 8'h00});
         @(negedge clk);
      end
      reset = 1'b0;
   endtask

   task automatic test_reset;
      pulse_reset(3);
      @(negedge clk);
      ncmp++;
      if (dma_active !== 1'b0) begin
         nerr++;
         $display("FAIL reset_active got=%b exp=0", dma_active);
      end
      ncmp++;
      if (rd_req !== 1'b0 || oam_wr_en !== 1'b0) begin
         nerr++;
         $display("FAIL reset_strobes got rq=%b wr=%b exp 0 0",
                  rd_req, oam_wr_en);
      end
      ncmp++;
      if (rd_addr !== 16'h0000) begin
         nerr++;
         $display("FAIL reset_rd_addr got=%h exp=0000", rd_addr);
      end
      ncmp++;
      if (oam_addr !== 8'h00 || oam_wdata !== 8'h00) begin
         nerr++;
         $display("FAIL reset_oam got a=%h d=%h exp 00 00",
                  oam_addr, oam_wdata);
      end
      ncmp++;
      if (reg_rdata !== 8'hFF) begin
         nerr++;
         $display("FAIL reset_rdata got=%h exp=ff", reg_rdata);
      end
   endtask

   task automatic test_basic;
      int n_act, n_wr, shown;
      obs_t e;
      bw = cyc;
      strobe(8'hC1);
      wait_until(bw + 661);
      shown = 0;
      for (int c = bw; c < bw + 660; c++) begin
         e = model(c);
         ncmp++;
         if (bad(obs[c], e)) begin
            nerr++;
            if (shown++ < 4)
               $display("FAIL basic cyc=%0d got=%h exp=%h", c, obs[c], e);
         end
      end
      n_act = 0;
      n_wr  = 0;
      for (int c = bw; c < bw + 660; c++) begin
         n_act += int'(obs[c].act);
         n_wr  += int'(obs[c].wr);
      end
      ncmp++;
      if (n_act != 644) begin
         nerr++;
         $display("FAIL basic_active_len got=%0d exp=644", n_act);
      end
      ncmp++;
      if (n_wr != NB) begin
         nerr++;
         $display("FAIL basic_write_count got=%0d exp=%0d", n_wr, NB);
      end
   endtask

   task automatic test_timing;
      int f_act, f_rq, s_rq, f_wr, l_wr, f_low;
      f_act = -1; f_rq = -1; s_rq = -1; f_wr = -1; l_wr = -1; f_low = -1;
      for (int c = bw; c < bw + 660; c++) begin
         if (obs[c].act && f_act < 0) f_act = c - bw;
         if (!obs[c].act && f_act >= 0 && f_low < 0) f_low = c - bw;
         if (obs[c].rq && f_rq >= 0 && s_rq < 0) s_rq = c - bw;
         if (obs[c].rq && f_rq < 0) f_rq = c - bw;
         if (obs[c].wr && f_wr < 0) f_wr = c - bw;
         if (obs[c].wr) l_wr = c - bw;
      end
      ncmp++;
      if (f_act != 1) begin
         nerr++;
         $display("FAIL tim_active_rise got=+%0d exp=+1", f_act);
      end
      ncmp++;
      if (f_rq != 5) begin
         nerr++;
         $display("FAIL tim_first_rd got=+%0d exp=+5", f_rq);
      end
      ncmp++;
      if (f_wr != 6) begin
         nerr++;
         $display("FAIL tim_first_wr got=+%0d exp=+6", f_wr);
      end
      ncmp++;
      if (s_rq != 9) begin
         nerr++;
         $display("FAIL tim_second_rd got=+%0d exp=+9", s_rq);
      end
      ncmp++;
      if (l_wr != 642) begin
         nerr++;
         $display("FAIL tim_last_wr got=+%0d exp=+642", l_wr);
      end
      ncmp++;
      if (f_low != 645) begin
         nerr++;
         $display("FAIL tim_active_fall got=+%0d exp=+645", f_low);
      end
   endtask

   task automatic test_echo;
      int w, shown;
      obs_t e;
      w = cyc;
      strobe(8'hE3);
      wait_until(w + 661);
      shown = 0;
      for (int c = w; c < w + 660; c++) begin
         e = model(c);
         ncmp++;
         if (bad(obs[c], e)) begin
            nerr++;
            if (shown++ < 4)
               $display("FAIL echo cyc=%0d got=%h exp=%h", c, obs[c], e);
         end
      end
      ncmp++;
      if (obs[w + 5].ra !== 16'hC300 || obs[w + 641].ra !== 16'hC39F) begin
         nerr++;
         $display("FAIL echo_addr got=%h..%h exp=c300..c39f",
                  obs[w + 5].ra, obs[w + 641].ra);
      end
      ncmp++;
      if (obs[w + 1].rb !== 8'hE3) begin
         nerr++;
         $display("FAIL echo_rdata got=%h exp=e3", obs[w + 1].rb);
      end
   endtask

   task automatic test_restart;
      int w, w2, n_wr, shown;
      obs_t e;
      w = cyc;
      strobe(8'hC0);
      wait_until(w + 1 + CPB * 51 + 2);
      w2 = cyc;
      strobe(8'hD0);
      wait_until(w2 + 661);
      shown = 0;
      for (int c = w; c < w2 + 660; c++) begin
         e = model(c);
         ncmp++;
         if (bad(obs[c], e)) begin
            nerr++;
            if (shown++ < 4)
               $display("FAIL restart cyc=%0d got=%h exp=%h", c, obs[c], e);
         end
      end
      n_wr = 0;
      for (int c = w2 + 1; c < w2 + 660; c++) n_wr += int'(obs[c].wr);
      ncmp++;
      if (n_wr != NB) begin
         nerr++;
         $display("FAIL restart_writes got=%0d exp=%0d", n_wr, NB);
      end
      ncmp++;
      if (obs[w2 + 5].ra !== 16'hD000 || obs[w2 + 1].rb !== 8'hD0) begin
         nerr++;
         $display("FAIL restart_src got ra=%h rb=%h exp d000 d0",
                  obs[w2 + 5].ra, obs[w2 + 1].rb);
      end
   endtask

   task automatic test_reset_mid;
      int w, r, n_wr, shown;
      obs_t e;
      w = cyc;
      strobe(8'($urandom_range(8'h80, 8'hFF)));
      wait_until(w + 1 + CPB * 81);
      r = cyc;
      pulse_reset(1);
      wait_until(r + 21);
      shown = 0;
      for (int c = w; c < r + 20; c++) begin
         e = model(c);
         ncmp++;
         if (bad(obs[c], e)) begin
            nerr++;
            if (shown++ < 4)
               $display("FAIL rstmid cyc=%0d got=%h exp=%h", c, obs[c], e);
         end
      end
      ncmp++;
      if (obs[r].rq !== 1'b1) begin
         nerr++;
         $display("FAIL rstmid_same_cycle got rq=%b exp=1", obs[r].rq);
      end
      n_wr = 0;
      for (int c = r + 1; c < r + 20; c++) n_wr += int'(obs[c].wr);
      ncmp++;
      if (n_wr != 0) begin
         nerr++;
         $display("FAIL rstmid_writes got=%0d exp=0", n_wr);
      end
      ncmp++;
      if (obs[r + 1].act !== 1'b0 || obs[r + 1].rb !== 8'hFF) begin
         nerr++;
         $display("FAIL rstmid_after got act=%b rb=%h exp 0 ff",
                  obs[r + 1].act, obs[r + 1].rb);
      end
   endtask

   task automatic test_back_to_back;
      int w, w2, n_act, shown;
      obs_t e;
      w = cyc;
      strobe(8'($urandom));
      wait_until(w + CPB * (NB + 1));
      w2 = cyc;
      strobe(8'($urandom));
      wait_until(w2 + 661);
      shown = 0;
      for (int c = w; c < w2 + 660; c++) begin
         e = model(c);
         ncmp++;
         if (bad(obs[c], e)) begin
            nerr++;
            if (shown++ < 4)
               $display("FAIL b2b cyc=%0d got=%h exp=%h", c, obs[c], e);
         end
      end
      n_act = 0;
      for (int c = w; c < w2 + 660; c++) n_act += int'(obs[c].act);
      ncmp++;
      if (n_act != 2 * 644) begin
         nerr++;
         $display("FAIL b2b_active_len got=%0d exp=%0d", n_act, 2 * 644);
      end
   endtask

   task automatic test_random;
      int w, w2, act, off, shown;
      obs_t e;
      for (int it = 0; it < 4; it++) begin
         w = cyc;
         strobe(8'($urandom));
         act = $urandom_range(0, 2);
         off = $urandom_range(1, 650);
         w2  = w;
         if (act != 0) begin
            wait_until(w + off);
            w2 = cyc;
            if (act == 1) strobe(8'($urandom));
            else pulse_reset(1);
         end
         wait_until(w2 + 661);
         shown = 0;
         for (int c = w; c < w2 + 660; c++) begin
            e = model(c);
            ncmp++;
            if (bad(obs[c], e)) begin
               nerr++;
               if (shown++ < 4)
                  $display("FAIL rand%0d cyc=%0d got=%h exp=%h",
                           it, c, obs[c], e);
            end
         end
      end
   endtask

   initial begin
      #180000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      @(negedge clk);
      test_reset();
      repeat (6) @(negedge clk);
      test_basic();
      test_timing();
      test_echo();
      test_restart();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
